// File: rtl/sevseg_scroll_ctrl_if.sv
// Avalon-MM register bus between a system master and the scroll controller.
interface sevseg_scroll_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sevseg_scroll_ctrl.sv
// Scrolling message window for a bank of eight 7-segment digits.
// Software fills a pattern buffer, sets step divisor and length, then enables
// scrolling; the block advances the window itself and drives all digits.
module sevseg_scroll_ctrl #(
    parameter int DEPTH = 16,
    parameter int DIV_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    sevseg_scroll_ctrl_if.slave bus,
    output logic [55:0]         digits_out,
    output logic                busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r;
    logic               enable_r;
    logic               oneshot_r;
    logic               done_r;
    logic [DIV_W-1:0]   div_r;
    logic [DIV_W-1:0]   cnt_r;
    logic [6:0]         len_r;
    logic [5:0]         pos_r;
    logic [6:0]         buf_r [DEPTH];
    logic [55:0]        digits_r;

    logic               wr_s;
    logic               ctrl_wr_s;
    logic               div_wr_s;
    logic               len_wr_s;
    logic               buf_wr_s;
    logic               en_next_s;
    logic               zero_s;
    logic               step_s;
    logic               wrap_s;
    logic [6:0]         len_clamp_s;
    logic [6:0]         sum_s [8];
    logic [55:0]        win_s;
    logic               unused_wd_s;

    assign wr_s      = bus.chipselect && !bus.write_n;
    assign ctrl_wr_s = wr_s && (bus.address == 3'd0);
    assign div_wr_s  = wr_s && (bus.address == 3'd1);
    assign len_wr_s  = wr_s && (bus.address == 3'd2);
    assign buf_wr_s  = wr_s && (bus.address == 3'd3);
    // A CTRL write decides the enable seen by the FSM on the same edge.
    assign en_next_s = ctrl_wr_s ? bus.writedata[0] : enable_r;
    // Restart and LEN writes both rewind the window and beat a coincident step.
    assign zero_s    = (ctrl_wr_s && bus.writedata[2]) || len_wr_s;
    assign step_s    = (cnt_r == div_r);
    assign wrap_s    = (({1'b0, pos_r} + 7'd1) == len_r);
    assign unused_wd_s = ^bus.writedata;

    assign digits_out = digits_r;
    assign busy       = (state_r == RUN);

    // Clamp a LEN write into the legal range 1..DEPTH.
    always_comb begin
        len_clamp_s = bus.writedata[6:0];
        if (bus.writedata[6:0] == 7'd0) begin
            len_clamp_s = 7'd1;
        end else if (bus.writedata[6:0] > 7'(DEPTH)) begin
            len_clamp_s = 7'(DEPTH);
        end else begin
            len_clamp_s = bus.writedata[6:0];
        end
    end

    // Register readback, combinational from address; unused bits read zero.
    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            3'd0:    bus.readdata = {30'd0, oneshot_r, enable_r};
            3'd1:    bus.readdata = 32'(div_r);
            3'd2:    bus.readdata = {25'd0, len_r};
            3'd4:    bus.readdata = {22'd0, done_r, busy, 2'd0, pos_r};
            default: bus.readdata = 32'd0;
        endcase
    end

    // Control registers, scroll FSM, step counter and window position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            enable_r  <= 1'b0;
            oneshot_r <= 1'b0;
            done_r    <= 1'b0;
            div_r     <= '0;
            cnt_r     <= '0;
            len_r     <= 7'd1;
            pos_r     <= 6'd0;
        end else begin
            if (ctrl_wr_s) begin
                enable_r  <= bus.writedata[0];
                oneshot_r <= bus.writedata[1];
                done_r    <= 1'b0;
            end
            if (div_wr_s) begin
                div_r <= bus.writedata[DIV_W-1:0];
            end
            if (len_wr_s) begin
                len_r <= len_clamp_s;
            end
            case (state_r)
                IDLE: begin
                    if (en_next_s) begin
                        state_r <= RUN;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    if (!en_next_s) begin
                        state_r <= IDLE;
                    end else if (zero_s) begin
                        state_r <= RUN;
                    end else if (step_s) begin
                        cnt_r <= '0;
                        pos_r <= wrap_s ? 6'd0 : pos_r + 6'd1;
                        if (oneshot_r && wrap_s) begin
                            done_r   <= 1'b1;
                            enable_r <= 1'b0;
                            state_r  <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + DIV_W'(1'b1);
                    end
                end
                default: state_r <= IDLE;
            endcase
            if (zero_s) begin
                pos_r <= 6'd0;
                cnt_r <= '0;
            end
        end
    end

    // Message buffer; entries beyond LEN are kept for later growth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_r[i] <= 7'h00;
            end
        end else if (buf_wr_s) begin
            buf_r[bus.writedata[AW+6:7]] <= bus.writedata[6:0];
        end
    end

    // Window lookup: digit k shows buf[(pos + 7 - k) mod LEN], blank past LEN.
    always_comb begin
        win_s = 56'd0;
        for (int k = 0; k < 8; k++) begin
            sum_s[k] = {1'b0, pos_r} + 7'(7 - k);
            if (sum_s[k] >= len_r) begin
                sum_s[k] = sum_s[k] - len_r;
            end else begin
                sum_s[k] = sum_s[k];
            end
            if (7'(7 - k) < len_r) begin
                win_s[7*k +: 7] = buf_r[sum_s[k][AW-1:0]];
            end else begin
                win_s[7*k +: 7] = 7'h00;
            end
        end
    end

    // Digit outputs are registered one cycle behind the window state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits_r <= 56'd0;
        end else begin
            digits_r <= win_s;
        end
    end
endmodule

// File: tb/tb_sevseg_scroll_ctrl.sv
// Directed bench for sevseg_scroll_ctrl: register table plus scroll sequences.
module tb_sevseg_scroll_ctrl;
    logic        clk;
    logic        reset_n;
    logic [55:0] digits_out;
    logic        busy;
    int          checks;
    int          errors;

    sevseg_scroll_ctrl_if bus ();

    sevseg_scroll_ctrl #(.DEPTH(16), .DIV_W(24)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .digits_out (digits_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  rd_addr;
        logic [31:0] exp_rd;
        logic        chk_dig;
        logic [55:0] exp_dig;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: write is sampled on the next posedge.
    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] addr, output logic [31:0] data);
        bus.address = addr;
        #1;
        data = bus.readdata;
    endtask

    logic [55:0] d_a;
    logic [55:0] d_b;
    logic [55:0] d_c;
    logic [31:0] r;
    logic [31:0] st_exp;
    int          p;

    initial begin
        checks = 0;
        errors = 0;
        bus.address    = 3'd0;
        bus.writedata  = 32'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset_n        = 1'b0;

        d_a = {7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08};
        d_b = {7'h01, 7'h02, 7'h03, 7'h04, 28'h0000000};
        d_c = {7'h01, 49'd0};

        vecs[0] = '{3'd2, 32'd10,          3'd2, 32'd10,  1'b1, d_a};
        vecs[1] = '{3'd2, 32'd4,           3'd2, 32'd4,   1'b1, d_b};
        vecs[2] = '{3'd2, 32'd0,           3'd2, 32'd1,   1'b1, d_c};
        vecs[3] = '{3'd2, 32'd20,          3'd2, 32'd16,  1'b1, d_a};
        vecs[4] = '{3'd1, 32'd3,           3'd1, 32'd3,   1'b1, d_a};
        vecs[5] = '{3'd3, 32'h0000_067F,   3'd3, 32'd0,   1'b1, d_a};
        vecs[6] = '{3'd5, 32'hFFFF_FFFF,   3'd5, 32'd0,   1'b0, 56'd0};
        vecs[7] = '{3'd2, 32'd10,          3'd4, 32'd0,   1'b1, d_a};
        vecs[8] = '{3'd0, 32'd2,           3'd0, 32'd2,   1'b1, d_a};
        vecs[9] = '{3'd0, 32'd4,           3'd0, 32'd0,   1'b1, d_a};

        // Reset state
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_digits", 64'(digits_out), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rd(3'd4, r); chk("reset_status", 64'(r), 64'd0);
        rd(3'd2, r); chk("reset_len", 64'(r), 64'd1);
        rd(3'd0, r); chk("reset_ctrl", 64'(r), 64'd0);

        // Load buf[0..9] = 1..10 while idle
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            wr(3'd3, (32'(i) << 7) | 32'(i + 1));
        end

        // Register table
        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            rd(vecs[i].rd_addr, r);
            chk($sformatf("row%0d_rd", i), 64'(r), 64'(vecs[i].exp_rd));
            if (vecs[i].chk_dig) begin
                chk($sformatf("row%0d_digits", i), 64'(digits_out), 64'(vecs[i].exp_dig));
            end
        end

        // Continuous scroll: LEN=10, DIV=3
        @(negedge clk);
        wr(3'd0, 32'd1);
        chk("run_busy", 64'(busy), 64'd1);
        @(negedge clk);
        for (int s = 1; s <= 10; s++) begin
            repeat (3) @(negedge clk);
            p = s % 10;
            st_exp = 32'h100 | 32'(p);
            rd(3'd4, r); chk($sformatf("run_status_s%0d", s), 64'(r), 64'(st_exp));
            @(negedge clk);
            chk($sformatf("run_digit7_s%0d", s), 64'(digits_out[55:49]), 64'(p + 1));
        end
        wr(3'd0, 32'd0);
        chk("stop_busy", 64'(busy), 64'd0);
        rd(3'd4, r); chk("stop_status", 64'(r), 64'd0);

        // Oneshot: DIV=0, LEN=5
        @(negedge clk);
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd5);
        wr(3'd0, 32'd3);
        chk("oneshot_busy", 64'(busy), 64'd1);
        repeat (4) @(negedge clk);
        rd(3'd4, r); chk("oneshot_pos4", 64'(r), 64'h104);
        @(negedge clk);
        rd(3'd4, r); chk("oneshot_done", 64'(r), 64'h200);
        chk("oneshot_idle", 64'(busy), 64'd0);
        rd(3'd0, r); chk("oneshot_ctrl", 64'(r), 64'd2);
        repeat (3) @(negedge clk);
        rd(3'd4, r); chk("oneshot_sticky", 64'(r), 64'h200);
        @(negedge clk);
        wr(3'd0, 32'd0);
        rd(3'd4, r); chk("done_clear", 64'(r), 64'd0);

        // Restart and LEN write colliding with a step (DIV=0)
        @(negedge clk);
        wr(3'd0, 32'd1);
        wr(3'd0, 32'd5);
        rd(3'd4, r); chk("restart_wins", 64'(r), 64'h100);
        @(negedge clk);
        rd(3'd4, r); chk("restart_runs", 64'(r), 64'h101);
        @(negedge clk);
        wr(3'd2, 32'd5);
        rd(3'd4, r); chk("lenwr_wins", 64'(r), 64'h100);

        // Async reset mid-run at pos 6
        @(negedge clk);
        wr(3'd2, 32'd10);
        repeat (6) @(negedge clk);
        rd(3'd4, r); chk("pre_reset_pos", 64'(r), 64'h106);
        reset_n = 1'b0;
        #1;
        chk("async_digits", 64'(digits_out), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        rd(3'd4, r); chk("async_status", 64'(r), 64'd0);
        rd(3'd2, r); chk("async_len", 64'(r), 64'd1);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        wr(3'd2, 32'd10);
        wr(3'd0, 32'd1);
        chk("rerun_busy", 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        chk("rerun_blank", 64'(digits_out), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
